// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: queue entry layout, PC step and default sizing
// used by the resolution queue and the predictor tables.
package bp_pkg;

   localparam int BP_DEPTH  = 4;
   localparam int BP_PC_W   = 32;
   localparam int BP_PC_INC = 4;

   // Entry layout {pc, pred, target}; the queue packs it at its own PC width.
   typedef struct packed {
      logic [BP_PC_W-1:0] pc;
      logic               pred;
      logic [BP_PC_W-1:0] target;
   } bp_entry_t;

   function automatic int bp_entry_w(input int pc_w);
      return 2 * pc_w + 1;
   endfunction

endpackage

// File: rtl/brq_entry_fifo.sv
// Storage array and head/tail/count bookkeeping for in-flight branches.
// A synchronous clear drops every entry by snapping head onto tail.
module brq_entry_fifo
   import bp_pkg::*;
#(
   parameter int DEPTH = BP_DEPTH,
   parameter int W     = bp_entry_w(BP_PC_W)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           clear,
   input  logic                           push,
   input  logic                           pop,
   input  logic [W-1:0]                   wdata,
   output logic [W-1:0]                   rdata,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   // Pointers wrap naturally because DEPTH is a power of two; count separates full from empty.
   always_comb begin
      head_d  = clear ? tail_q : (pop ? head_q + PW'(1) : head_q);
      tail_d  = (push && !clear) ? tail_q + PW'(1) : tail_q;
      count_d = clear ? CW'(0) : count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= PW'(0);
         tail_q  <= PW'(0);
         count_q <= CW'(0);
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear) begin
         mem_q[tail_q] <= wdata;
      end
   end

   assign rdata = mem_q[head_q];
   assign count = count_q;
   assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/branch_resolution_queue.sv
// Holds predicted branches in program order, checks each resolution against its prediction,
// and emits registered predictor-update and mispredict/redirect pulses one cycle later.
module branch_resolution_queue
   import bp_pkg::*;
#(
   parameter int DEPTH = BP_DEPTH,
   parameter int PC_W  = BP_PC_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       fetch_valid,
   output logic                       fetch_ready,
   input  logic [PC_W-1:0]            fetch_pc,
   input  logic                       fetch_pred,
   input  logic [PC_W-1:0]            fetch_target,
   input  logic                       resolve_valid,
   input  logic                       resolve_taken,
   input  logic [PC_W-1:0]            resolve_target,
   output logic                       update_en,
   output logic                       outcome,
   output logic [PC_W-1:0]            update_pc,
   output logic                       mispredict,
   output logic [PC_W-1:0]            redirect_pc,
   output logic                       resolve_err,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int ENTRY_W = bp_entry_w(PC_W);
   localparam int CW      = $clog2(DEPTH+1);

   logic [ENTRY_W-1:0] head_s;
   logic [PC_W-1:0]    head_pc_s, head_tgt_s, redirect_s;
   logic               head_pred_s;
   logic               full_s, enq_s, res_s, mis_s, flush_s, push_s, pop_s;
   logic [CW-1:0]      count_s;

   logic               update_en_q, outcome_q, mispredict_q, resolve_err_q;
   logic [PC_W-1:0]    update_pc_q, redirect_q;

   assign {head_pc_s, head_pred_s, head_tgt_s} = head_s;

   assign enq_s = fetch_valid & ~full_s;
   assign res_s = resolve_valid & (count_s != CW'(0));

   // A target mismatch only matters when both prediction and outcome say taken.
   always_comb begin
      mis_s      = (head_pred_s != resolve_taken) |
                   (head_pred_s & resolve_taken & (head_tgt_s != resolve_target));
      redirect_s = resolve_taken ? resolve_target : head_pc_s + PC_W'(BP_PC_INC);
   end

   // A mispredict flushes everything, including any wrong-path enqueue in the same cycle.
   assign flush_s = res_s & mis_s;
   assign push_s  = enq_s & ~flush_s;
   assign pop_s   = res_s & ~mis_s;

   brq_entry_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (flush_s),
      .push  (push_s),
      .pop   (pop_s),
      .wdata ({fetch_pc, fetch_pred, fetch_target}),
      .rdata (head_s),
      .count (count_s),
      .full  (full_s)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         update_en_q   <= 1'b0;
         outcome_q     <= 1'b0;
         update_pc_q   <= {PC_W{1'b0}};
         mispredict_q  <= 1'b0;
         redirect_q    <= {PC_W{1'b0}};
         resolve_err_q <= 1'b0;
      end else begin
         update_en_q   <= res_s;
         mispredict_q  <= flush_s;
         resolve_err_q <= resolve_err_q | (resolve_valid & (count_s == CW'(0)));
         if (res_s) begin
            outcome_q   <= resolve_taken;
            update_pc_q <= head_pc_s;
            redirect_q  <= redirect_s;
         end
      end
   end

   assign fetch_ready = ~full_s;
   assign count       = count_s;
   assign update_en   = update_en_q;
   assign outcome     = outcome_q;
   assign update_pc   = update_pc_q;
   assign mispredict  = mispredict_q;
   assign redirect_pc = redirect_q;
   assign resolve_err = resolve_err_q;

endmodule
